bit_serial_subtractor: RTL
==========================

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 8, setting operand and result width; legal range 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, active-high asynchronous reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a subtraction, sampled on the rising edge of clk.
REQ-005 The block SHALL have port A, input, N bits, the minuend, captured when start is accepted.
REQ-006 The block SHALL have port B, input, N bits, the subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port Bin, input, 1 bit, the borrow-in, captured when start is accepted.
REQ-008 The block SHALL have port Diff, output, N bits, the registered result A - B - Bin modulo 2^N.
REQ-009 The block SHALL have port Bout, output, 1 bit, the registered borrow-out; it is 1 iff A < B + Bin as unsigned values.
REQ-010 The block SHALL have port V, output, 1 bit, the registered two's-complement overflow flag.
REQ-011 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-012 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-014 In IDLE, when start is high at a clock edge, the block SHALL load A, B and Bin into internal shift registers and a borrow flip-flop, clear the bit counter, and go to RUN.
REQ-015 In RUN, the block SHALL process exactly one bit per cycle, LSB first, through a single one-bit full-subtractor stage: d = a ^ b ^ br; br_next = (~a & b) | (~(a ^ b) & br).
REQ-016 The block SHALL shift each d into the result shift register from the MSB end, so the result is bit-aligned after N shifts.
REQ-017 On the edge that processes bit N-1, the block SHALL update Diff, Bout and V, pulse done high for exactly one cycle, and return to IDLE.
REQ-018 V SHALL equal (A[N-1] != B[N-1]) && (Diff[N-1] != A[N-1]), computed from the captured operands.
REQ-019 Latency: if start is sampled at edge t0, done SHALL be high in the cycle following edge t0+N.
REQ-020 busy SHALL be high in the cycles following edges t0 through t0+N-1, and low otherwise.
REQ-021 Diff, Bout and V SHALL hold their last result until the next completion; they SHALL NOT change during RUN.
REQ-022 start while busy SHALL be ignored, and A, B and Bin changes during RUN SHALL NOT affect the result.
REQ-023 start asserted in the cycle where done is high SHALL be accepted, giving back-to-back operations with no idle gap.
REQ-024 The bit counter SHALL be ceil(log2(N)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE and clear Diff, Bout, V, busy, done, the counter, the shift registers and the borrow flip-flop to 0.
REQ-026 Reset asserted mid-operation SHALL abort that operation, and no done pulse SHALL follow it.
REQ-027 After reset deasserts, the first start sampled SHALL be accepted normally.

Verification (N=8)
REQ-028 A=100, B=37, Bin=0 -> Diff=63, Bout=0, V=0; done exactly 8 cycles after the start edge, with busy high for 8 cycles.
REQ-029 A=5, B=10, Bin=0 -> Diff=0xFB, Bout=1, V=0.
REQ-030 A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0, V=1; and A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1, V=0.
REQ-031 Second start held high throughout the first operation, then A=0x10, B=0x01 presented on the done cycle -> first result unaffected, second done 8 cycles later with Diff=0x0F.
REQ-032 Reset asserted 3 cycles into an operation -> all outputs 0 immediately and no done pulse; a new start then completes correctly.
REQ-033 Exhaustive randomized check of all A, B and Bin values against a reference model -> Diff, Bout and V match on every done pulse.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per cycle, LSB first,
// through a single full-subtractor stage, and publishes the registered result
// with a one-cycle done pulse.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous active-high reset
//   start  - begin a subtraction (accepted only when idle)
//   A, B   - minuend / subtrahend, captured on accept
//   Bin    - borrow-in, captured on accept
//   Diff   - registered A - B - Bin modulo 2^N
//   Bout   - registered borrow-out (A < B + Bin, unsigned)
//   V      - registered two's-complement overflow flag
//   busy   - high while an operation is in progress
//   done   - one-cycle completion pulse
module bit_serial_subtractor #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         V,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  // Holds the N-1 bits already produced; the last bit joins it on completion.
  logic [N-2:0]  res_sr;
  logic          br;
  logic [CW-1:0] cnt;

  logic          d_c;
  logic          br_next_c;
  logic          last_c;
  logic [N-1:0]  res_shift_c;
  logic          load_c;
  logic          step_c;
  logic          busy_next_c;
  logic          done_next_c;

  // One-bit full-subtractor stage on the current LSBs.
  assign d_c       = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last_c    = (cnt == CW'(N - 1));
  assign res_shift_c = {d_c, res_sr};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    state_next  = state;
    load_c      = 1'b0;
    step_c      = 1'b0;
    busy_next_c = 1'b0;
    done_next_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next  = RUN;
          load_c      = 1'b1;
          busy_next_c = 1'b1;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) begin
          state_next  = IDLE;
          done_next_c = 1'b1;
        end else begin
          busy_next_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      Diff   <= '0;
      Bout   <= 1'b0;
      V      <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= busy_next_c;
      done <= done_next_c;
      if (load_c) begin
        a_sr   <= A;
        b_sr   <= B;
        br     <= Bin;
        res_sr <= '0;
        cnt    <= '0;
      end else if (step_c) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        br     <= br_next_c;
        res_sr <= res_shift_c[N-1:1];
        if (!last_c) cnt <= cnt + CW'(1);
        if (last_c) begin
          Diff <= res_shift_c;
          Bout <= br_next_c;
          // On the final bit the shift registers' LSBs are the operand MSBs.
          V    <= (a_sr[0] != b_sr[0]) && (d_c != a_sr[0]);
        end
      end
    end
  end

endmodule
